fifo_v4: RTL and testbench
==========================

FIFO_V4 -- requirements
Module: fifo_v4

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- FALL_THROUGH, 0: when 1, a push into an empty FIFO is visible on data_o in the same cycle.
- DATA_WIDTH, 32: entry width in bits.
- DEPTH, 8: number of entries; legal range 2..65536; need not be a power of two.
- CNT_WIDTH, $clog2(DEPTH+1): derived width; SHALL NOT be overridden.
REQ-002 The one clock and the reset SHALL be exactly as stated here: one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk_i, in, 1: clock; all state updates on the rising edge.
- rst_i, in, 1: synchronous active-high reset.
- flush_i, in, 1: synchronous clear of the stored contents.
- clr_err_i, in, 1: clears the sticky error flags.
- alm_full_th_i, in, CNT_WIDTH: run-time almost-full threshold.
- alm_empty_th_i, in, CNT_WIDTH: run-time almost-empty threshold.
- data_i, in, DATA_WIDTH: write data.
- push_i, in, 1: write request.
- data_o, out, DATA_WIDTH: head entry.
- pop_i, in, 1: read request.
- usage_o, out, CNT_WIDTH: number of stored entries, 0..DEPTH; does not wrap.
- full_o, empty_o, out, 1 each: status.
- alm_full_o, alm_empty_o, out, 1 each: threshold status.
- overflow_o, underflow_o, out, 1 each: sticky error flags.

Function
REQ-004 Storage SHALL be a circular buffer with read and write pointers that wrap from DEPTH-1 to 0, plus a separate occupancy counter of CNT_WIDTH bits.
REQ-005 A push SHALL be accepted when push_i=1 and either full_o=0 or a pop is accepted in the same cycle (non-fall-through mode only).
- An accepted push writes data_i at the write pointer and advances the write pointer.
REQ-006 A pop SHALL be accepted when pop_i=1 and empty_o=0.
- An accepted pop advances the read pointer.
REQ-007 Next-cycle usage SHALL be computed as follows:
- push accepted and pop not accepted: usage+1.
- pop accepted and push not accepted: usage-1.
- both or neither accepted: unchanged.
REQ-008 full_o SHALL equal (usage_o==DEPTH) and empty_o SHALL equal (usage_o==0).
- When FALL_THROUGH=1, empty_o SHALL instead be 0 whenever usage_o==0 and push_i=1.
REQ-009 With FALL_THROUGH=0, data_o SHALL be the entry at the read pointer, registered with zero-cycle read latency from storage.
- A pushed word is observable on data_o no earlier than the cycle after the push.
REQ-010 With FALL_THROUGH=1 and usage_o==0, data_o SHALL equal data_i combinationally.
- If push_i and pop_i are both 1 in that state, the word passes through: no entry is written, usage_o stays 0, and no underflow is flagged.
REQ-011 Push when full:
- With FALL_THROUGH=0 and pop_i=1, both operations SHALL be accepted and usage_o SHALL stay DEPTH.
- Otherwise the push SHALL be dropped, storage SHALL be unchanged, and overflow_o SHALL be set on the next cycle.
REQ-012 A pop when empty (excluding the pass-through case in REQ-010) SHALL be ignored and underflow_o SHALL be set on the next cycle.
REQ-013 Once set, overflow_o and underflow_o SHALL hold until clr_err_i=1 or rst_i=1.
- If clr_err_i and a new error occur in the same cycle, the flag SHALL remain set.
REQ-014 alm_full_o SHALL be 1 when usage_o >= alm_full_th_i; alm_empty_o SHALL be 1 when usage_o <= alm_empty_th_i.
- Both are combinational from the registered count and the current threshold inputs.
- Threshold values greater than DEPTH SHALL be saturated to DEPTH.
REQ-015 When flush_i=1 (and rst_i=0), the next cycle SHALL have pointers=0 and usage_o=0.
- push_i and pop_i in the flush cycle SHALL be ignored and SHALL NOT set error flags.
- Error flags SHALL be preserved across a flush.
REQ-016 Storage contents SHALL NOT be reset; data_o SHALL be don't-care while empty_o=1 (except in the REQ-010 pass-through).

Reset
REQ-017 When rst_i=1 at a rising edge, the next cycle SHALL have:
- pointers=0, usage_o=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0;
- alm_empty_o=1 and alm_full_o = (alm_full_th_i==0).
REQ-018 rst_i SHALL take priority over flush_i, clr_err_i, push_i and pop_i.
- A reset in the middle of a burst SHALL discard all entries.
REQ-019 There SHALL be no asynchronous path from rst_i to any output.

Verification (DEPTH=4, DATA_WIDTH=8, FALL_THROUGH=0 unless stated)
REQ-020 Fill and wrap:
- Stimulus: push 0x11,0x22,0x33,0x44, then pop 2, push 0x55,0x66, then pop 4.
- Response: full_o=1 after the 4th push; pop order is 0x11,0x22,0x33,0x44,0x55,0x66; empty_o=1 at the end.
REQ-021 Full boundary:
- Stimulus: at usage 4, push 0x77 with pop_i=0; next, push 0x88 with pop_i=1.
- Response: 0x77 is dropped and overflow_o=1; the simultaneous push and pop is accepted with usage_o staying 4; 0x88 is later read last.
REQ-022 Fall-through (FALL_THROUGH=1):
- Stimulus: empty FIFO, push 0xA5 and pop in the same cycle.
- Response: data_o=0xA5 and empty_o=0 in that cycle; usage_o stays 0; underflow_o=0.
REQ-023 Errors:
- Stimulus: pop when empty; then clr_err_i=1; then pop when empty with clr_err_i=1.
- Response: underflow_o=1 on the next cycle; cleared after the clr_err_i cycle; on the last step underflow_o stays 1.
REQ-024 Thresholds:
- Stimulus: alm_full_th_i=3, alm_empty_th_i=1, then push 3; then change alm_full_th_i to 6.
- Response: alm_empty_o is 1 at usage 0..1 and 0 at usage 2..3; alm_full_o=1 at usage 3; with threshold 6 (saturated to 4) at usage 3, alm_full_o=0.
REQ-025 Flush and reset:
- Stimulus: at usage 3, assert flush_i with push_i=1; later, with usage 2 and overflow_o=1, assert rst_i together with flush_i and push_i.
- Response: after the flush usage_o=0, no entry is written and overflow_o is unchanged; after the reset all outputs match REQ-017.

Source files
------------

// File: rtl/fifo_v4.sv
// Circular-buffer FIFO with occupancy counter, run-time almost-full/empty thresholds,
// sticky overflow/underflow flags and an optional fall-through path for an empty FIFO.
module fifo_v4 #(
    parameter int FALL_THROUGH = 0,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 8,
    parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  clr_err_i,
    input  logic [CNT_WIDTH-1:0]  alm_full_th_i,
    input  logic [CNT_WIDTH-1:0]  alm_empty_th_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  push_i,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  pop_i,
    output logic [CNT_WIDTH-1:0]  usage_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  alm_full_o,
    output logic                  alm_empty_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);
    localparam int                   PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_WIDTH-1:0] DEPTH_C   = CNT_WIDTH'(DEPTH);
    localparam logic [PTR_WIDTH-1:0] LAST_C    = PTR_WIDTH'(DEPTH - 1);
    localparam bit                   FT        = (FALL_THROUGH != 0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_WIDTH-1:0]  usage_q, usage_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  is_empty, is_full, pass_thru;
    logic                  push_acc, pop_acc, ovf_evt, unf_evt, wr_en;
    logic [CNT_WIDTH-1:0]  af_th, ae_th;

    assign is_empty  = (usage_q == '0);
    assign is_full   = (usage_q == DEPTH_C);
    // Fall-through: a word pushed and popped into an empty FIFO bypasses storage entirely.
    assign pass_thru = FT && is_empty && push_i && pop_i;
    assign pop_acc   = pop_i && !is_empty;
    assign push_acc  = push_i && !pass_thru && (!is_full || (!FT && pop_i));
    assign ovf_evt   = push_i && !push_acc && !pass_thru;
    assign unf_evt   = pop_i && is_empty && !pass_thru;
    assign wr_en     = push_acc && !flush_i && !rst_i;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        usage_d  = usage_q;
        ovf_d    = ovf_q && !clr_err_i;
        unf_d    = unf_q && !clr_err_i;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            usage_d  = '0;
        end else begin
            if (push_acc) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + 1'b1;
            if (pop_acc)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + 1'b1;
            if (push_acc && !pop_acc)      usage_d = usage_q + 1'b1;
            else if (pop_acc && !push_acc) usage_d = usage_q - 1'b1;
            // A new error wins over a same-cycle clear.
            ovf_d = ovf_d || ovf_evt;
            unf_d = unf_d || unf_evt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            usage_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            usage_q  <= usage_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wr_ptr_q] <= data_i;
    end

    assign af_th = (alm_full_th_i  > DEPTH_C) ? DEPTH_C : alm_full_th_i;
    assign ae_th = (alm_empty_th_i > DEPTH_C) ? DEPTH_C : alm_empty_th_i;

    assign data_o      = (FT && is_empty) ? data_i : mem_q[rd_ptr_q];
    assign usage_o     = usage_q;
    assign full_o      = is_full;
    assign empty_o     = is_empty && !(FT && push_i);
    assign alm_full_o  = (usage_q >= af_th);
    assign alm_empty_o = (usage_q <= ae_th);
    assign overflow_o  = ovf_q;
    assign underflow_o = unf_q;
endmodule

// File: tb/tb_fifo_v4.sv
// Bench for fifo_v4: directed scenarios plus randomized traffic against a queue-based model.
module tb_fifo_v4;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    localparam int CW = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst, flush, clr, push, pop;
    logic [CW-1:0] afth, aeth;
    logic [DW-1:0] din;

    logic [DW-1:0] dout, ft_dout;
    logic [CW-1:0] usage, ft_usage;
    logic full, empty, afull, aempty, ovf, unf;
    logic ft_full, ft_empty, ft_afull, ft_aempty, ft_ovf, ft_unf;

    fifo_v4 #(.FALL_THROUGH(0), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .clr_err_i(clr),
        .alm_full_th_i(afth), .alm_empty_th_i(aeth), .data_i(din), .push_i(push),
        .data_o(dout), .pop_i(pop), .usage_o(usage), .full_o(full), .empty_o(empty),
        .alm_full_o(afull), .alm_empty_o(aempty), .overflow_o(ovf), .underflow_o(unf)
    );

    fifo_v4 #(.FALL_THROUGH(1), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut_ft (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .clr_err_i(clr),
        .alm_full_th_i(afth), .alm_empty_th_i(aeth), .data_i(din), .push_i(push),
        .data_o(ft_dout), .pop_i(pop), .usage_o(ft_usage), .full_o(ft_full), .empty_o(ft_empty),
        .alm_full_o(ft_afull), .alm_empty_o(ft_aempty), .overflow_o(ft_ovf), .underflow_o(ft_unf)
    );

    always #5 clk = ~clk;

    // Reference model of the non-fall-through instance.
    logic [DW-1:0] q[$];
    bit m_ovf, m_unf;
    int n_cmp = 0;
    int n_err = 0;

    function automatic int sat(input int th);
        return (th > DEPTH) ? DEPTH : th;
    endfunction

    task automatic model_update();
        bit was_full, was_empty, pop_ok, push_ok;
        if (rst) begin
            q.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (flush) begin
            q.delete();
            m_ovf = m_ovf && !clr;
            m_unf = m_unf && !clr;
        end else begin
            was_full  = (q.size() == DEPTH);
            was_empty = (q.size() == 0);
            pop_ok  = pop && !was_empty;
            push_ok = push && (!was_full || pop);
            m_ovf = (m_ovf && !clr) || (push && !push_ok);
            m_unf = (m_unf && !clr) || (pop && was_empty);
            if (pop_ok) void'(q.pop_front());
            if (push_ok) q.push_back(din);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle();
        rst = 0; flush = 0; clr = 0; push = 0; pop = 0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        step();
        rst = 0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; flush = 1; push = 1; pop = 1; clr = 1; din = 8'h5A;
        afth = 0; aeth = 0;
        step();
        idle();
        #1;
        n_cmp++; if (usage !== 0) begin n_err++; $display("FAIL reset_usage got %0d want 0", usage); end
        n_cmp++; if (empty !== 1'b1 || full !== 1'b0) begin n_err++; $display("FAIL reset_status empty=%b full=%b want 1/0", empty, full); end
        n_cmp++; if (ovf !== 1'b0 || unf !== 1'b0) begin n_err++; $display("FAIL reset_err ovf=%b unf=%b want 0/0", ovf, unf); end
        n_cmp++; if (aempty !== 1'b1 || afull !== 1'b1) begin n_err++; $display("FAIL reset_alm th0 aempty=%b afull=%b want 1/1", aempty, afull); end
        afth = 2; #1;
        n_cmp++; if (afull !== 1'b0) begin n_err++; $display("FAIL reset_alm_full th2 got %b want 0", afull); end
    endtask

    task automatic test_fill_wrap();
        logic [DW-1:0] exp_d [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        int k = 0;
        afth = 7; aeth = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin push = 1; din = exp_d[i]; step(); end
        push = 0; #1;
        n_cmp++; if (full !== 1'b1 || usage !== 4) begin n_err++; $display("FAIL fill_full full=%b usage=%0d want 1/4", full, usage); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (dout !== exp_d[k]) begin n_err++; $display("FAIL wrap_pop%0d got %h want %h", k, dout, exp_d[k]); end
            k++; pop = 1; step(); pop = 0;
        end
        for (int i = 4; i < 6; i++) begin push = 1; din = exp_d[i]; step(); end
        push = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (dout !== exp_d[k]) begin n_err++; $display("FAIL wrap_pop%0d got %h want %h", k, dout, exp_d[k]); end
            k++; pop = 1; step(); pop = 0;
        end
        #1;
        n_cmp++; if (empty !== 1'b1 || usage !== 0) begin n_err++; $display("FAIL wrap_empty empty=%b usage=%0d want 1/0", empty, usage); end
    endtask

    task automatic test_full_boundary();
        logic [DW-1:0] exp_d [4] = '{8'hA2, 8'hA3, 8'hA4, 8'h88};
        do_reset();
        for (int i = 1; i <= 4; i++) begin push = 1; din = DW'(8'hA0 + i); step(); end
        din = 8'h77; push = 1; pop = 0; step();
        n_cmp++; if (ovf !== 1'b1 || usage !== 4) begin n_err++; $display("FAIL full_drop ovf=%b usage=%0d want 1/4", ovf, usage); end
        din = 8'h88; push = 1; pop = 1; step();
        idle(); #1;
        n_cmp++; if (usage !== 4 || full !== 1'b1) begin n_err++; $display("FAIL full_pushpop usage=%0d full=%b want 4/1", usage, full); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (dout !== exp_d[i]) begin n_err++; $display("FAIL full_order%0d got %h want %h", i, dout, exp_d[i]); end
            pop = 1; step(); pop = 0; #1;
        end
    endtask

    task automatic test_fall_through();
        do_reset();
        din = 8'hA5; push = 1; pop = 1; #1;
        n_cmp++; if (ft_dout !== 8'hA5 || ft_empty !== 1'b0) begin n_err++; $display("FAIL ft_pass data=%h empty=%b want a5/0", ft_dout, ft_empty); end
        step();
        n_cmp++; if (ft_usage !== 0 || ft_unf !== 1'b0) begin n_err++; $display("FAIL ft_pass_after usage=%0d unf=%b want 0/0", ft_usage, ft_unf); end
        din = 8'h3C; pop = 0; #1;
        n_cmp++; if (ft_dout !== 8'h3C || ft_empty !== 1'b0) begin n_err++; $display("FAIL ft_push data=%h empty=%b want 3c/0", ft_dout, ft_empty); end
        step();
        din = 8'h00; push = 0; #1;
        n_cmp++; if (ft_usage !== 1 || ft_dout !== 8'h3C) begin n_err++; $display("FAIL ft_stored usage=%0d data=%h want 1/3c", ft_usage, ft_dout); end
        pop = 1; step(); pop = 1; step(); pop = 0;
        n_cmp++; if (ft_unf !== 1'b1) begin n_err++; $display("FAIL ft_underflow got %b want 1", ft_unf); end
    endtask

    task automatic test_errors();
        do_reset();
        pop = 1; step();
        n_cmp++; if (unf !== 1'b1) begin n_err++; $display("FAIL err_set got %b want 1", unf); end
        pop = 0; clr = 1; step();
        n_cmp++; if (unf !== 1'b0) begin n_err++; $display("FAIL err_clr got %b want 0", unf); end
        pop = 1; clr = 1; step();
        idle();
        n_cmp++; if (unf !== 1'b1) begin n_err++; $display("FAIL err_clr_race got %b want 1", unf); end
    endtask

    task automatic test_thresholds();
        do_reset();
        afth = 3; aeth = 1;
        for (int i = 0; i <= 3; i++) begin
            #1;
            n_cmp++; if (aempty !== (i <= 1) || afull !== (i >= 3)) begin
                n_err++; $display("FAIL thr_u%0d aempty=%b afull=%b want %b/%b", i, aempty, afull, i <= 1, i >= 3);
            end
            if (i < 3) begin push = 1; din = DW'(i); step(); push = 0; end
        end
        afth = 6; #1;
        n_cmp++; if (afull !== 1'b0) begin n_err++; $display("FAIL thr_sat_u3 got %b want 0", afull); end
        push = 1; step(); push = 0; #1;
        n_cmp++; if (afull !== 1'b1) begin n_err++; $display("FAIL thr_sat_u4 got %b want 1", afull); end
    endtask

    task automatic test_flush_reset();
        do_reset();
        afth = 3; aeth = 0;
        for (int i = 0; i < 5; i++) begin push = 1; din = DW'(8'hC0 + i); step(); end
        push = 0; pop = 1; step(); pop = 0;
        n_cmp++; if (usage !== 3 || ovf !== 1'b1) begin n_err++; $display("FAIL flush_pre usage=%0d ovf=%b want 3/1", usage, ovf); end
        flush = 1; push = 1; din = 8'hEE; step(); idle();
        n_cmp++; if (usage !== 0 || empty !== 1'b1 || ovf !== 1'b1) begin
            n_err++; $display("FAIL flush_post usage=%0d empty=%b ovf=%b want 0/1/1", usage, empty, ovf);
        end
        push = 1; din = 8'h01; step(); din = 8'h02; step(); push = 0; #1;
        n_cmp++; if (dout !== 8'h01 || usage !== 2) begin n_err++; $display("FAIL flush_nowrite data=%h usage=%0d want 01/2", dout, usage); end
        rst = 1; flush = 1; push = 1; step(); idle(); #1;
        n_cmp++; if (usage !== 0 || empty !== 1'b1 || full !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0 || aempty !== 1'b1 || afull !== 1'b0) begin
            n_err++; $display("FAIL rst_burst usage=%0d e=%b f=%b ovf=%b unf=%b ae=%b af=%b want 0/1/0/0/0/1/0", usage, empty, full, ovf, unf, aempty, afull);
        end
    endtask

    task automatic test_random();
        int n;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            push  = ($urandom % 100) < 55;
            pop   = ($urandom % 100) < 45;
            din   = DW'($urandom);
            flush = ($urandom % 50) == 0;
            clr   = ($urandom % 25) == 0;
            rst   = ($urandom % 200) == 0;
            if (($urandom % 16) == 0) begin afth = CW'($urandom % 8); aeth = CW'($urandom % 8); end
            #1;
            n = q.size();
            n_cmp++; if (usage !== CW'(n) || empty !== (n == 0) || full !== (n == DEPTH)) begin
                n_err++; $display("FAIL rnd_status c=%0d usage=%0d e=%b f=%b want %0d", c, usage, empty, full, n);
            end
            n_cmp++; if (afull !== (n >= sat(int'(afth))) || aempty !== (n <= sat(int'(aeth)))) begin
                n_err++; $display("FAIL rnd_alm c=%0d af=%b ae=%b usage=%0d th=%0d/%0d", c, afull, aempty, n, afth, aeth);
            end
            n_cmp++; if (ovf !== m_ovf || unf !== m_unf) begin
                n_err++; $display("FAIL rnd_err c=%0d ovf=%b unf=%b want %b/%b", c, ovf, unf, m_ovf, m_unf);
            end
            if (n > 0) begin
                n_cmp++; if (dout !== q[0]) begin n_err++; $display("FAIL rnd_data c=%0d got %h want %h", c, dout, q[0]); end
            end
            step();
        end
        idle();
    endtask

    initial begin
        idle();
        din = '0; afth = '0; aeth = '0;
        test_reset();
        test_fill_wrap();
        test_full_boundary();
        test_fall_through();
        test_errors();
        test_thresholds();
        test_flush_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
